// File: rtl/axi_interconnect_sport_rd_adapter.sv
// AXI4 read slave-port adapter: AR -> addr_info and resp_info -> R through 2-entry skid slices, 1-cycle latency.
// Backpressure: registered readies drop when a slice holds two entries or NUM_OUTSTANDING bursts are open.
module axi_interconnect_sport_rd_adapter #(
  parameter int WIDTH_ID        = 4,
  parameter int WIDTH_ADDR      = 32,
  parameter int WIDTH_DATA      = 32,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                             clk_sys,
  input  logic                             rst_n,
  input  logic [WIDTH_ID-1:0]              s_axi_arid,
  input  logic [WIDTH_ADDR-1:0]            s_axi_araddr,
  input  logic [7:0]                       s_axi_arlen,
  input  logic [2:0]                       s_axi_arsize,
  input  logic [1:0]                       s_axi_arburst,
  input  logic                             s_axi_arlock,
  input  logic [3:0]                       s_axi_arcache,
  input  logic [2:0]                       s_axi_arprot,
  input  logic [3:0]                       s_axi_arqos,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [WIDTH_ID-1:0]              s_axi_rid,
  output logic [WIDTH_DATA-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rlast,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [WIDTH_ID+WIDTH_ADDR+28:0]  m_addr_info,
  output logic                             m_addr_valid,
  input  logic                             m_addr_ready,
  input  logic [WIDTH_ID+WIDTH_DATA+2:0]   m_resp_info,
  input  logic                             m_resp_valid,
  output logic                             m_resp_ready,
  output logic [3:0]                       outstanding_cnt,
  output logic                             err_underflow
);

  localparam int WIDTH_ADDRINFO = WIDTH_ID + WIDTH_ADDR + 29;
  localparam int WIDTH_RESPINFO = WIDTH_ID + WIDTH_DATA + 3;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam logic [3:0] CNT_MAX  = 4'(NUM_OUTSTANDING);

  logic [1:0]                ar_st_q, ar_st_d, r_st_q, r_st_d;
  logic [WIDTH_ADDRINFO-1:0] ar_dat0_q, ar_dat0_d, ar_dat1_q, ar_dat1_d, ar_in;
  logic [WIDTH_RESPINFO-1:0] r_dat0_q, r_dat0_d, r_dat1_q, r_dat1_d;
  logic                      ar_rdy_q, ar_rdy_d, r_rdy_q, r_rdy_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      ar_in_hs, ar_out_hs, r_in_hs, r_out_hs, inc, dec;

  // Four spare MSBs pad the packed AR fields up to the crossbar slice width.
  assign ar_in = {4'b0000, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                  s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  assign s_axi_arready   = ar_rdy_q & rst_n;
  assign m_resp_ready    = r_rdy_q & rst_n;
  assign m_addr_valid    = (ar_st_q != ST_EMPTY);
  assign s_axi_rvalid    = (r_st_q != ST_EMPTY);
  assign m_addr_info     = ar_dat0_q;
  assign s_axi_rid       = r_dat0_q[WIDTH_RESPINFO-1 -: WIDTH_ID];
  assign s_axi_rdata     = r_dat0_q[WIDTH_DATA+2:3];
  assign s_axi_rresp     = r_dat0_q[2:1];
  assign s_axi_rlast     = r_dat0_q[0];
  assign outstanding_cnt = cnt_q;
  assign err_underflow   = err_q;

  assign ar_in_hs  = s_axi_arvalid & s_axi_arready;
  assign ar_out_hs = m_addr_valid & m_addr_ready;
  assign r_in_hs   = m_resp_valid & m_resp_ready;
  assign r_out_hs  = s_axi_rvalid & s_axi_rready;
  assign inc       = ar_in_hs;
  assign dec       = r_out_hs & s_axi_rlast;

  always_comb begin
    ar_st_d   = ar_st_q;
    ar_dat0_d = ar_dat0_q;
    ar_dat1_d = ar_dat1_q;
    case (ar_st_q)
      ST_EMPTY: if (ar_in_hs) begin
        ar_dat0_d = ar_in;
        ar_st_d   = ST_ONE;
      end
      ST_ONE: begin
        if (ar_in_hs && ar_out_hs) begin
          ar_dat0_d = ar_in;
        end else if (ar_in_hs) begin
          ar_dat1_d = ar_in;
          ar_st_d   = ST_TWO;
        end else if (ar_out_hs) begin
          ar_st_d   = ST_EMPTY;
        end
      end
      ST_TWO: if (ar_out_hs) begin
        ar_dat0_d = ar_dat1_q;
        ar_st_d   = ST_ONE;
      end
      default: ar_st_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    r_st_d   = r_st_q;
    r_dat0_d = r_dat0_q;
    r_dat1_d = r_dat1_q;
    case (r_st_q)
      ST_EMPTY: if (r_in_hs) begin
        r_dat0_d = m_resp_info;
        r_st_d   = ST_ONE;
      end
      ST_ONE: begin
        if (r_in_hs && r_out_hs) begin
          r_dat0_d = m_resp_info;
        end else if (r_in_hs) begin
          r_dat1_d = m_resp_info;
          r_st_d   = ST_TWO;
        end else if (r_out_hs) begin
          r_st_d   = ST_EMPTY;
        end
      end
      ST_TWO: if (r_out_hs) begin
        r_dat0_d = r_dat1_q;
        r_st_d   = ST_ONE;
      end
      default: r_st_d = ST_EMPTY;
    endcase
  end

  // Readies are computed from next-cycle occupancy/count so they can be registered.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 4'd1;
    end else if (dec && !inc) begin
      if (cnt_q == 4'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 4'd1;
    end
    ar_rdy_d = (ar_st_d != ST_TWO) && (cnt_d != CNT_MAX);
    r_rdy_d  = (r_st_d != ST_TWO);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ar_st_q   <= ST_EMPTY;
      ar_dat0_q <= '0;
      ar_dat1_q <= '0;
      r_st_q    <= ST_EMPTY;
      r_dat0_q  <= '0;
      r_dat1_q  <= '0;
      ar_rdy_q  <= 1'b1;
      r_rdy_q   <= 1'b1;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      ar_st_q   <= ar_st_d;
      ar_dat0_q <= ar_dat0_d;
      ar_dat1_q <= ar_dat1_d;
      r_st_q    <= r_st_d;
      r_dat0_q  <= r_dat0_d;
      r_dat1_q  <= r_dat1_d;
      ar_rdy_q  <= ar_rdy_d;
      r_rdy_q   <= r_rdy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_interconnect_sport_rd_adapter.sv
// Bench for the AXI read slave-port adapter: queue-based model checked every cycle plus literal spot checks.
module tb_axi_interconnect_sport_rd_adapter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arlock;
  logic [3:0]  s_axi_arcache;
  logic [2:0]  s_axi_arprot;
  logic [3:0]  s_axi_arqos;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [64:0] m_addr_info;
  logic        m_addr_valid;
  logic        m_addr_ready;
  logic [38:0] m_resp_info;
  logic        m_resp_valid;
  logic        m_resp_ready;
  logic [3:0]  outstanding_cnt;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  logic [64:0] aq[$];
  logic [38:0] rq[$];
  int          m_cnt = 0;
  logic        m_err = 1'b0;

  axi_interconnect_sport_rd_adapter #(
    .WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_DATA(32), .NUM_OUTSTANDING(N)
  ) dut (
    .clk_sys(clk), .rst_n(rst_n),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_addr_info(m_addr_info), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .m_resp_info(m_resp_info), .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .outstanding_cnt(outstanding_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the queue model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    logic ar_hs, a_out, r_in, r_out, inc, dec;
    if (!rst_n) begin
      chk("arready_in_reset", s_axi_arready, 1'b0);
      chk("resp_ready_in_reset", m_resp_ready, 1'b0);
      aq.delete();
      rq.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      chk("cnt", outstanding_cnt, m_cnt);
      chk("err_underflow", err_underflow, m_err);
      chk("m_addr_valid", m_addr_valid, aq.size() != 0);
      chk("s_axi_rvalid", s_axi_rvalid, rq.size() != 0);
      chk("s_axi_arready", s_axi_arready, (aq.size() < 2) && (m_cnt != N));
      chk("m_resp_ready", m_resp_ready, rq.size() < 2);
      if (m_addr_valid && aq.size() != 0) chk("addr_info", m_addr_info, aq[0]);
      if (s_axi_rvalid && rq.size() != 0)
        chk("r_payload", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, rq[0]);
      ar_hs = s_axi_arvalid && s_axi_arready;
      a_out = m_addr_valid && m_addr_ready && aq.size() != 0;
      r_in  = m_resp_valid && m_resp_ready;
      r_out = s_axi_rvalid && s_axi_rready && rq.size() != 0;
      inc = ar_hs;
      dec = r_out && rq[0][0];
      if (a_out) void'(aq.pop_front());
      if (ar_hs) aq.push_back({4'b0000, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
                               s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos});
      if (r_out) void'(rq.pop_front());
      if (r_in) rq.push_back(m_resp_info);
      if (inc && !dec) m_cnt++;
      else if (dec && !inc) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic acc;
    int   n;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arlock = 1'b0;
    s_axi_arcache = 4'h3; s_axi_arprot = 3'b010; s_axi_arqos = id;
    s_axi_arvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = s_axi_arready;
      tick();
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!acc) chk("ar_handshake_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_resp(input logic [3:0] id, input logic [31:0] data, input logic last);
    logic acc;
    int   n;
    m_resp_info = {id, data, 2'b00, last};
    m_resp_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = m_resp_ready;
      tick();
      n++;
    end
    m_resp_valid = 1'b0;
    if (!acc) chk("resp_handshake_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; m_addr_ready = 1'b1;
    m_resp_info = '0; m_resp_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr_valid", m_addr_valid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_cnt", outstanding_cnt, 4'd0);
    chk("rst_err", err_underflow, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single AR, fields pinned by hand.
    send_ar(4'd3, 32'h0000_1000, 8'd3);
    @(negedge clk);
    chk("single_valid", m_addr_valid, 1'b1);
    chk("single_arid", m_addr_info[60:57], 4'h3);
    chk("single_araddr", m_addr_info[56:25], 32'h0000_1000);
    chk("single_arlen", m_addr_info[24:17], 8'd3);
    chk("single_pad", m_addr_info[64:61], 4'h0);
    chk("single_cnt", outstanding_cnt, 4'd1);

    // Four R beats with rready toggling; count falls only on the last.
    s_axi_rready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_resp(4'd3, 32'hA0 + i, i == 3);
      end
      begin
        for (int i = 0; i < 14; i++) begin
          tick();
          s_axi_rready = ~s_axi_rready;
        end
        s_axi_rready = 1'b1;
      end
    join
    repeat (4) tick();
    @(negedge clk);
    chk("burst_done_cnt", outstanding_cnt, 4'd0);
    tick();

    // Fill to the outstanding limit.
    for (int i = 0; i < 4; i++) send_ar(4'(i), 32'h2000 + 32'(i * 16), 8'd0);
    @(negedge clk);
    chk("limit_cnt", outstanding_cnt, 4'd4);
    chk("limit_arready", s_axi_arready, 1'b0);
    tick();
    send_resp(4'd0, 32'h5555_0000, 1'b1);
    @(negedge clk);
    chk("limit_arready_hold", s_axi_arready, 1'b0);
    tick();
    @(negedge clk);
    chk("limit_arready_rise", s_axi_arready, 1'b1);
    chk("limit_cnt_after", outstanding_cnt, 4'd3);
    tick();
    for (int i = 1; i < 4; i++) send_resp(4'(i), 32'h5555_0000 + i, 1'b1);
    repeat (4) tick();

    // Downstream stall: AR slice fills, then drains in order.
    m_addr_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_ar(4'(4 + i), 32'h3000 + 32'(i * 4), 8'(i));
      end
      begin
        repeat (4) tick();
        @(negedge clk);
        chk("stall_full_arready", s_axi_arready, 1'b0);
        chk("stall_valid", m_addr_valid, 1'b1);
        tick();
        m_addr_ready = 1'b1;
      end
    join
    repeat (4) tick();
    for (int i = 0; i < 4; i++) send_resp(4'(4 + i), 32'hC0 + i, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("stall_drain_cnt", outstanding_cnt, 4'd0);
    tick();

    // RLAST with nothing outstanding.
    send_resp(4'd9, 32'hDEAD_BEEF, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("underflow_err", err_underflow, 1'b1);
    chk("underflow_cnt", outstanding_cnt, 4'd0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("underflow_cleared", err_underflow, 1'b0);
    tick();

    // Reset with traffic buffered in both directions.
    m_addr_ready = 1'b0;
    s_axi_rready = 1'b0;
    send_ar(4'd1, 32'h4000, 8'd1);
    send_ar(4'd2, 32'h4010, 8'd1);
    send_resp(4'd1, 32'h1234_5678, 1'b0);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_addr_valid", m_addr_valid, 1'b0);
    chk("midrst_rvalid", s_axi_rvalid, 1'b0);
    chk("midrst_cnt", outstanding_cnt, 4'd0);
    tick();
    rst_n = 1'b1;
    m_addr_ready = 1'b1;
    s_axi_rready = 1'b1;
    tick();
    send_ar(4'd5, 32'h5000, 8'd0);
    @(negedge clk);
    chk("resume_cnt", outstanding_cnt, 4'd1);
    tick();
    send_resp(4'd5, 32'h0000_00FF, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("resume_cnt_done", outstanding_cnt, 4'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
